// File: rtl/id_scoreboard_if.sv
// Issue / write-back / status bundle between decode and the register scoreboard.
// Latency: none (wires only).
// Backpressure: issue_ready/stall flow from the scoreboard back to decode; write-back has no backpressure.
interface id_scoreboard_if;
  // issue side
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        use_rs1;
  logic        use_rs2;
  logic        issue_wr;
  logic [4:0]  issue_rd;
  // write-back side
  logic        wb_valid;
  logic [4:0]  wb_rd;
  // control
  logic        flush;
  // status
  logic        issue_ready;
  logic        stall;
  logic [31:0] busy;
  logic [3:0]  count;
  logic        err;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, use_rs1, use_rs2, issue_wr, issue_rd,
    output wb_valid, wb_rd, flush,
    input  issue_ready, stall, busy, count, err
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, use_rs1, use_rs2, issue_wr, issue_rd,
    input  wb_valid, wb_rd, flush,
    output issue_ready, stall, busy, count, err
  );
endinterface

// File: rtl/id_scoreboard.sv
// Register scoreboard: tracks up to DEPTH in-order outstanding register writes and blocks RAW/WAW hazards.
// Latency: issue_ready is combinational from registered state; busy/count update one cycle after issue/write-back.
// Backpressure: issue_ready drops on hazard, full tracker (writing issue) or flush; write-backs are never stalled.
module id_scoreboard #(
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  id_scoreboard_if.slave sb
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   busy_q;
  logic [3:0]    count_q;
  logic          err_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [4:0]    fifo_q [DEPTH];

  logic          rd_nz;
  logic          raw1;
  logic          raw2;
  logic          waw;
  logic          full;
  logic          ready;
  logic          push;
  logic          pop;
  logic          wb_bad;
  logic [4:0]    head;
  logic [31:0]   set_vec;
  logic [31:0]   clr_vec;

  // Hazard detection, issue acceptance and write-back matching against the oldest outstanding write.
  // Only registered busy is consulted, so a write-back in the same cycle never unblocks an issue.
  always_comb begin
    rd_nz   = (sb.issue_rd != 5'd0);
    raw1    = sb.use_rs1 & (sb.issue_rs1 != 5'd0) & busy_q[sb.issue_rs1];
    raw2    = sb.use_rs2 & (sb.issue_rs2 != 5'd0) & busy_q[sb.issue_rs2];
    waw     = sb.issue_wr & rd_nz & busy_q[sb.issue_rd];
    full    = (count_q == 4'(DEPTH));
    ready   = ~raw1 & ~raw2 & ~waw & ~(sb.issue_wr & rd_nz & full) & ~sb.flush;
    push    = sb.issue_valid & ready & sb.issue_wr & rd_nz;
    head    = fifo_q[rd_ptr_q];
    pop     = sb.wb_valid & (count_q != 4'd0) & (sb.wb_rd == head) & ~sb.flush;
    wb_bad  = sb.wb_valid & ~pop & ~sb.flush;
    set_vec = push ? ((32'd1 << sb.issue_rd) & ~32'd1) : 32'd0;
    clr_vec = pop  ? (32'd1 << head) : 32'd0;
  end

  // Pending-write bitmap: set on writing issue, clear on accepted write-back, wiped by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 32'd0;
    end else if (sb.flush) begin
      busy_q <= 32'd0;
    end else begin
      busy_q <= (busy_q | set_vec) & ~clr_vec;
    end
  end

  // In-order tracker pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
    end else if (sb.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Tracker storage holds destination register numbers; contents are don't-care when empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= sb.issue_rd;
  end

  // Sticky protocol error: write-back with nothing outstanding or out of order; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (wb_bad) begin
      err_q <= 1'b1;
    end
  end

  assign sb.issue_ready = ready;
  assign sb.stall       = sb.issue_valid & ~ready;
  assign sb.busy        = busy_q;
  assign sb.count       = count_q;
  assign sb.err         = err_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: directed scenarios followed by randomized traffic against a queue-based model.
// Latency: model expects status one cycle after each edge, issue_ready combinationally.
// Backpressure: model derives readiness from its own pending-write list.
module tb_id_scoreboard;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_scoreboard_if sb_if();
  id_scoreboard #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .sb(sb_if));

  int n_chk  = 0;
  int n_pass = 0;

  // Model: ordered list of outstanding destination registers plus sticky error.
  logic [4:0] pend[$];
  bit         m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit pending(input logic [4:0] r);
    foreach (pend[i]) if (pend[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = 32'd0;
    foreach (pend[i]) b[pend[i]] = 1'b1;
    return b;
  endfunction

  function automatic bit m_ready();
    bit hz;
    hz = (sb_if.use_rs1 && sb_if.issue_rs1 != 0 && pending(sb_if.issue_rs1)) ||
         (sb_if.use_rs2 && sb_if.issue_rs2 != 0 && pending(sb_if.issue_rs2)) ||
         (sb_if.issue_wr && sb_if.issue_rd != 0 &&
          (pending(sb_if.issue_rd) || pend.size() == DEPTH)) ||
         sb_if.flush;
    return !hz;
  endfunction

  task automatic set_issue(input bit v, input bit wr, input logic [4:0] rd,
                           input bit u1, input logic [4:0] rs1,
                           input bit u2, input logic [4:0] rs2);
    sb_if.issue_valid = v;
    sb_if.issue_wr    = wr;
    sb_if.issue_rd    = rd;
    sb_if.use_rs1     = u1;
    sb_if.issue_rs1   = rs1;
    sb_if.use_rs2     = u2;
    sb_if.issue_rs2   = rs2;
  endtask

  task automatic set_wb(input bit v, input logic [4:0] rd);
    sb_if.wb_valid = v;
    sb_if.wb_rd    = rd;
  endtask

  task automatic idle();
    set_issue(0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    set_wb(0, 5'd0);
    sb_if.flush = 1'b0;
  endtask

  // Called with inputs already driven at posedge+1; ends at the next posedge+1.
  task automatic cycle();
    bit rdy, fire, wb_ok, wbv, wr, fl;
    logic [4:0] rd;
    #1;
    rdy = m_ready();
    chk("issue_ready", sb_if.issue_ready, rdy);
    chk("stall", sb_if.stall, sb_if.issue_valid & !rdy);
    fire  = sb_if.issue_valid && rdy;
    wr    = sb_if.issue_wr;
    rd    = sb_if.issue_rd;
    wbv   = sb_if.wb_valid;
    fl    = sb_if.flush;
    wb_ok = 1'b0;
    if (wbv && pend.size() != 0) wb_ok = (pend[0] == sb_if.wb_rd);
    @(posedge clk);
    if (fl) begin
      pend.delete();
    end else begin
      if (wb_ok) void'(pend.pop_front());
      else if (wbv) m_err = 1'b1;
      if (fire && wr && rd != 0) pend.push_back(rd);
    end
    #1;
    chk("busy", sb_if.busy, m_busy());
    chk("count", sb_if.count, pend.size());
    chk("err", sb_if.err, m_err);
  endtask

  // Starts at posedge+1; pulses reset between edges and returns at a later posedge+1.
  task automatic async_reset();
    #3 reset = 1'b1;
    #1;
    chk("rst_busy", sb_if.busy, 32'd0);
    chk("rst_count", sb_if.count, 4'd0);
    chk("rst_err", sb_if.err, 1'b0);
    pend.delete();
    m_err = 1'b0;
    set_issue(1, 1, 5'd5, 0, 5'd0, 0, 5'd0);
    #1;
    chk("rst_ready", sb_if.issue_ready, 1'b1);
    @(posedge clk);
    #1;
    chk("rst_hold_count", sb_if.count, 4'd0);
    idle();
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    pend.delete();
    m_err = 1'b0;
    #1;
    chk("init_busy", sb_if.busy, 32'd0);
    chk("init_count", sb_if.count, 4'd0);
    chk("init_err", sb_if.err, 1'b0);
    chk("init_ready", sb_if.issue_ready, 1'b1);
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    // Load to x5, dependent read stalls until the cycle after write-back.
    set_issue(1, 1, 5'd5, 0, 5'd0, 0, 5'd0); cycle();
    set_issue(1, 0, 5'd0, 1, 5'd5, 0, 5'd0);
    #1 chk("raw_stall", sb_if.stall, 1'b1);
    cycle();
    chk("raw_busy5", sb_if.busy[5], 1'b1);
    chk("raw_count", sb_if.count, 4'd1);
    set_wb(1, 5'd5);
    #1 chk("raw_stall_wb_same", sb_if.stall, 1'b1);
    cycle();
    set_wb(0, 5'd0);
    #1 chk("raw_ready_after", sb_if.issue_ready, 1'b1);
    cycle();
    chk("raw_busy5_clr", sb_if.busy[5], 1'b0);
    idle();

    // Fill the tracker, then a writing issue blocks even with a same-cycle retire.
    for (int r = 1; r <= 4; r++) begin
      set_issue(1, 1, 5'(r), 0, 5'd0, 0, 5'd0); cycle();
    end
    chk("full_count", sb_if.count, 4'd4);
    set_issue(1, 1, 5'd6, 0, 5'd0, 0, 5'd0);
    set_wb(1, 5'd1);
    #1 chk("full_stall", sb_if.stall, 1'b1);
    cycle();
    set_wb(0, 5'd0);
    cycle();
    chk("full_refill_count", sb_if.count, 4'd4);
    idle();
    for (int r = 2; r <= 4; r++) begin
      set_wb(1, 5'(r)); cycle();
    end
    set_wb(1, 5'd6); cycle();
    idle();

    // Out-of-order write-back flags error without disturbing state.
    set_issue(1, 1, 5'd7, 0, 5'd0, 0, 5'd0); cycle();
    set_issue(1, 1, 5'd8, 0, 5'd0, 0, 5'd0); cycle();
    idle();
    set_wb(1, 5'd8); cycle();
    chk("ooo_err", sb_if.err, 1'b1);
    chk("ooo_busy78", {30'd0, sb_if.busy[8], sb_if.busy[7]}, 32'd3);
    chk("ooo_count", sb_if.count, 4'd2);
    set_wb(1, 5'd7); cycle();
    chk("ooo_count_after", sb_if.count, 4'd1);
    chk("ooo_err_sticky", sb_if.err, 1'b1);
    set_wb(1, 5'd8); cycle();
    idle();

    // x0 destination/source never stalls or tracks.
    for (int k = 0; k < 5; k++) begin
      set_issue(1, 1, 5'd0, 1, 5'd0, 0, 5'd0);
      #1 chk("x0_stall", sb_if.stall, 1'b0);
      cycle();
    end
    chk("x0_count", sb_if.count, 4'd0);
    idle();

    // Flush wins over simultaneous issue and write-back.
    for (int r = 10; r <= 12; r++) begin
      set_issue(1, 1, 5'(r), 0, 5'd0, 0, 5'd0); cycle();
    end
    chk("pre_flush_count", sb_if.count, 4'd3);
    set_issue(1, 1, 5'd9, 0, 5'd0, 0, 5'd0);
    set_wb(1, 5'd10);
    sb_if.flush = 1'b1;
    cycle();
    chk("flush_count", sb_if.count, 4'd0);
    chk("flush_busy", sb_if.busy, 32'd0);
    chk("flush_busy9", sb_if.busy[9], 1'b0);
    idle();

    // Asynchronous reset between edges with state and error pending.
    set_issue(1, 1, 5'd13, 0, 5'd0, 0, 5'd0); cycle();
    set_issue(1, 1, 5'd14, 0, 5'd0, 0, 5'd0); cycle();
    idle();
    chk("pre_rst_count", sb_if.count, 4'd2);
    chk("pre_rst_err", sb_if.err, 1'b1);
    async_reset();

    // Randomized traffic on a small register range to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      if (n % 400 == 399) begin
        idle();
        async_reset();
      end else begin
        set_issue($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)));
        if (pend.size() > 0 && $urandom_range(0, 9) < 9)
          set_wb($urandom_range(0, 9) < 4, pend[0]);
        else
          set_wb($urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)));
        sb_if.flush = ($urandom_range(0, 29) == 0);
        cycle();
      end
    end

    idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
